// File: rtl/tx_escseq_serializer.sv
// SpaceWire escape-sequence serializer: time-codes, interrupts and interrupt
// acknowledges sent as ESC + data character, data-strobe encoded.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for slot_free and a pending request
// S_LOAD  | one cycle: ack pulse out, frame/divisor/line state latched
// S_SHIFT | 14 bit periods, each tx_clk_div+1 clocks long
// S_DONE  | one cycle: done pulse, busy dropped
module tx_escseq_serializer #(
  parameter int DIV_W  = 8,
  parameter int INT_EN = 1
) (
  input  logic             pclk_tx,
  input  logic             reset_tx,
  input  logic [DIV_W-1:0] tx_clk_div,
  input  logic             slot_free,
  input  logic             last_dout,
  input  logic             last_sout,
  input  logic             prev_parity,
  input  logic             tc_req,
  input  logic [7:0]       tc_value,
  input  logic             int_req,
  input  logic [5:0]       int_id,
  input  logic             ack_req,
  input  logic [5:0]       ack_id,
  output logic             tc_ack,
  output logic             int_ack,
  output logic             ack_ack,
  output logic             busy,
  output logic             done,
  output logic             tx_dout_esc,
  output logic             tx_sout_esc,
  output logic             parity_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic [3:0]       bits_left;
  logic [13:0]      frame;
  logic             prev_d;
  logic             prev_s;

  logic             int_ok;
  logic             ack_ok;
  logic             pick_tc;
  logic             pick_int;
  logic             pick_ack;
  logic             start;
  logic [7:0]       sel_payload;
  logic             esc_b0;

  // Interrupt sources are masked entirely when the feature is disabled.
  assign int_ok   = (INT_EN != 0) && int_req;
  assign ack_ok   = (INT_EN != 0) && ack_req;
  assign pick_tc  = tc_req;
  assign pick_int = !tc_req && int_ok;
  assign pick_ack = !tc_req && !int_ok && ack_ok;
  assign start    = (state == S_IDLE) && slot_free && (pick_tc || pick_int || pick_ack);

  always_comb begin
    sel_payload = tc_value;
    if (pick_int)      sel_payload = {2'b10, int_id};
    else if (pick_ack) sel_payload = {2'b11, ack_id};
  end

  // ESC parity bit covers the previous character's data bits plus this control flag.
  assign esc_b0 = ~(prev_parity ^ 1'b1);

  always_ff @(posedge pclk_tx or posedge reset_tx) begin
    if (reset_tx) begin
      state       <= S_IDLE;
      div_q       <= '0;
      cnt         <= '0;
      bits_left   <= 4'd0;
      frame       <= 14'd0;
      prev_d      <= 1'b0;
      prev_s      <= 1'b0;
      tc_ack      <= 1'b0;
      int_ack     <= 1'b0;
      ack_ack     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tx_dout_esc <= 1'b0;
      tx_sout_esc <= 1'b0;
      parity_out  <= 1'b0;
    end else begin
      tc_ack  <= 1'b0;
      int_ack <= 1'b0;
      ack_ack <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_LOAD;
            busy       <= 1'b1;
            tc_ack     <= pick_tc;
            int_ack    <= pick_int;
            ack_ack    <= pick_ack;
            // frame[0] is sent first: ESC parity, ESC = 1,1,1, data parity 1, flag 0, payload.
            frame      <= {sel_payload, 5'b01111, esc_b0};
            div_q      <= tx_clk_div;
            prev_d     <= last_dout;
            prev_s     <= last_sout;
            parity_out <= ^sel_payload;
          end
        end
        S_LOAD: begin
          state       <= S_SHIFT;
          tx_dout_esc <= frame[0];
          tx_sout_esc <= (frame[0] == prev_d) ? ~prev_s : prev_s;
          frame       <= frame >> 1;
          cnt         <= div_q;
          bits_left   <= 4'd13;
        end
        S_SHIFT: begin
          if (cnt == '0) begin
            if (bits_left == 4'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              bits_left   <= bits_left - 4'd1;
              cnt         <= div_q;
              tx_dout_esc <= frame[0];
              tx_sout_esc <= (frame[0] == tx_dout_esc) ? ~tx_sout_esc : tx_sout_esc;
              frame       <= frame >> 1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
